escaner_teclado: RTL and testbench

- Parametrised matrix-keypad scanner; successor to the fixed 4x4 combinational row/column-to-hex encoder.
- Drives one-hot row strobes and samples asynchronous column inputs through a 2-flop synchroniser.
- Debounces press and release, then emits a binary key code with a one-cycle valid pulse.
- Sits between the keypad pins and the downstream entry/accumulator logic.

---
 rtl/escaner_teclado_pkg.sv | 28 ++
 rtl/escaner_teclado_codificador.sv | 24 ++
 rtl/escaner_teclado.sv | 166 ++++++++++++++++
 tb/tb_escaner_teclado.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/escaner_teclado_pkg.sv
// Shared types and helpers for the matrix-keypad scanner (escaner_teclado).
// Holds the FSM state type, the key-code width rule and a population count.
package teclado_pkg;

  typedef enum logic [1:0] {
    ESCANEO,
    CONFIRMA,
    PRESIONADA,
    LIBERA
  } estado_t;

  // Widest vector contar_unos() accepts; narrower callers zero-extend.
  localparam int unsigned CUENTA_MAX_W = 64;

  function automatic int code_w(input int filas, input int columnas);
    return $clog2(filas * columnas);
  endfunction

  function automatic int unsigned contar_unos(input logic [CUENTA_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < CUENTA_MAX_W; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/escaner_teclado_codificador.sv
// One-hot to binary index encoder; valido is low unless exactly one bit is set.
// Used by escaner_teclado to turn the active column line into a column index.
module codificador_onehot
  import teclado_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valido
);

  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // idx unassigned would make synthesis infer a latch.
    idx    = '0;
    valido = (contar_unos(CUENTA_MAX_W'(onehot)) == 1);
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/escaner_teclado.sv
// Parametrised matrix-keypad scanner: row strobing, column sync, press/release
// debounce and key-code output. Optional auto-repeat under `AUTOREPEAT_EN.
module escaner_teclado
  import teclado_pkg::*;
#(
  parameter int FILAS           = 4,
  parameter int COLUMNAS        = 4,
  parameter int SCAN_CICLOS     = 1000,
  parameter int DEBOUNCE_CICLOS = 10000,
  parameter int REPEAT_CICLOS   = 5000000,
  localparam int CODE_W         = code_w(FILAS, COLUMNAS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [COLUMNAS-1:0] columna_i,
  output logic [FILAS-1:0]    fila_o,
  output logic [CODE_W-1:0]   tecla_codigo,
  output logic                tecla_valida,
  output logic                tecla_presionada,
  output logic                error_multi
);

  localparam int FILA_W = $clog2(FILAS);
  localparam int COL_W  = $clog2(COLUMNAS);
  localparam int SCAN_W = $clog2(SCAN_CICLOS);
  localparam int DEB_W  = $clog2(DEBOUNCE_CICLOS);

  estado_t             estado;
  logic [COLUMNAS-1:0] col_meta;
  logic [COLUMNAS-1:0] col_s;
  logic [COLUMNAS-1:0] col_lat;
  logic [FILA_W-1:0]   fila_idx;
  logic [FILA_W-1:0]   fila_sig;
  logic [FILAS-1:0]    fila_sig_oh;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [DEB_W-1:0]    deb_cnt;
  logic [COL_W-1:0]    col_idx;
  logic                col_unica;
  logic [CODE_W-1:0]   codigo_actual;

`ifdef AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CICLOS);
  logic [REP_W-1:0] rep_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= '0;
      col_s    <= '0;
    end else begin
      // NOTE: non-blocking so the second flop takes the first flop's old
      // value; blocking assignments would collapse the chain into one flop.
      col_meta <= columna_i;
      col_s    <= col_meta;
    end
  end

  codificador_onehot #(.N(COLUMNAS)) u_cod_col (
    .onehot (col_s),
    .idx    (col_idx),
    .valido (col_unica)
  );

  always_comb begin
    fila_sig              = (fila_idx == FILA_W'(FILAS - 1)) ? '0 : fila_idx + FILA_W'(1);
    fila_sig_oh           = '0;
    fila_sig_oh[fila_sig] = 1'b1;
    codigo_actual         = CODE_W'(fila_idx) * CODE_W'(COLUMNAS) + CODE_W'(col_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado           <= ESCANEO;
      fila_idx         <= '0;
      fila_o           <= FILAS'(1);
      scan_cnt         <= '0;
      deb_cnt          <= '0;
      col_lat          <= '0;
      tecla_codigo     <= '0;
      tecla_valida     <= 1'b0;
      tecla_presionada <= 1'b0;
      error_multi      <= 1'b0;
`ifdef AUTOREPEAT_EN
      rep_cnt          <= '0;
`endif
    end else begin
      tecla_valida <= 1'b0;
      error_multi  <= 1'b0;
      case (estado)
        ESCANEO: begin
          // Columns are only trusted at the end of the strobe window, once
          // the new row has propagated through the pad and the synchroniser.
          if (scan_cnt == SCAN_W'(SCAN_CICLOS - 1)) begin
            scan_cnt <= '0;
            if (col_unica) begin
              col_lat <= col_s;
              deb_cnt <= '0;
              estado  <= CONFIRMA;
            end else begin
              error_multi <= (col_s != '0);
              fila_idx    <= fila_sig;
              fila_o      <= fila_sig_oh;
            end
          end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
          end
        end

        CONFIRMA: begin
          if (col_s != col_lat) begin
            estado   <= ESCANEO;
            fila_idx <= fila_sig;
            fila_o   <= fila_sig_oh;
          end else if (deb_cnt == DEB_W'(DEBOUNCE_CICLOS - 1)) begin
            tecla_codigo     <= codigo_actual;
            tecla_valida     <= 1'b1;
            tecla_presionada <= 1'b1;
            estado           <= PRESIONADA;
`ifdef AUTOREPEAT_EN
            rep_cnt          <= '0;
`endif
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        PRESIONADA: begin
          // Only the latched column matters; extra keys on the row are ignored.
          if ((col_s & col_lat) == '0) begin
            deb_cnt <= '0;
            estado  <= LIBERA;
`ifdef AUTOREPEAT_EN
            rep_cnt <= '0;
          end else if (rep_cnt == REP_W'(REPEAT_CICLOS - 1)) begin
            rep_cnt      <= '0;
            tecla_valida <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
`endif
          end
        end

        LIBERA: begin
          if ((col_s & col_lat) != '0) begin
            estado  <= PRESIONADA;
`ifdef AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
          end else if (col_s != '0) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_W'(DEBOUNCE_CICLOS - 1)) begin
            tecla_presionada <= 1'b0;
            estado           <= ESCANEO;
            fila_idx         <= fila_sig;
            fila_o           <= fila_sig_oh;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        default: estado <= ESCANEO;
      endcase
    end
  end

endmodule

// File: tb/tb_escaner_teclado.sv
// Self-checking bench for escaner_teclado: a keypad-matrix model drives the
// columns from the row strobe; expectations come from the scanner's timing rules.
module tb_escaner_teclado;

  localparam int FILAS    = 4;
  localparam int COLUMNAS = 4;
  localparam int SCAN     = 4;
  localparam int DEB      = 8;
  localparam int REP      = 32;
  localparam int NK       = FILAS * COLUMNAS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] columna_i = '0;
  logic [3:0] fila_o;
  logic [3:0] tecla_codigo;
  logic       tecla_valida;
  logic       tecla_presionada;
  logic       error_multi;

  escaner_teclado #(
    .FILAS(FILAS), .COLUMNAS(COLUMNAS), .SCAN_CICLOS(SCAN),
    .DEBOUNCE_CICLOS(DEB), .REPEAT_CICLOS(REP)
  ) dut (
    .clk(clk), .rst(rst), .columna_i(columna_i), .fila_o(fila_o),
    .tecla_codigo(tecla_codigo), .tecla_valida(tecla_valida),
    .tecla_presionada(tecla_presionada), .error_multi(error_multi)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int row_start = 0;
  logic [3:0] prev_fila = '0;
  bit pressed[NK];
  int pulse_codes[$];
  int pulse_cycles[$];
  int err_cycles[$];

  // Keypad matrix: a held key connects its row strobe to its column line.
  function automatic logic [3:0] keypad_cols(input logic [3:0] filas);
    logic [3:0] c;
    c = '0;
    for (int k = 0; k < NK; k++)
      if (pressed[k] && filas[k / COLUMNAS]) c[k % COLUMNAS] = 1'b1;
    return c;
  endfunction

  function automatic logic [3:0] row_oh(input int r);
    logic [3:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  // One clock: sample outputs at the falling edge, then drive the pad.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (fila_o !== prev_fila) row_start = cyc;
    prev_fila = fila_o;
    if (tecla_valida === 1'b1) begin
      pulse_codes.push_back(int'(tecla_codigo));
      pulse_cycles.push_back(cyc);
    end
    if (error_multi === 1'b1) err_cycles.push_back(cyc);
    columna_i = keypad_cols(fila_o);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic release_all();
    for (int k = 0; k < NK; k++) pressed[k] = 1'b0;
  endtask

  task automatic wait_row(input int r);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(fila_o === row_oh(r) && row_start == cyc) && n < 200);
    total++;
    if (!(fila_o === row_oh(r) && row_start == cyc)) begin
      bad++;
      $display("FAIL wait_row: row %0d never started, fila_o=%b", r, fila_o);
    end
  endtask

  // Press key k just before its row is strobed, return on that row's first cycle.
  task automatic arm_key(input int k);
    int r = k / COLUMNAS;
    wait_row((r + FILAS - 1) % FILAS);
    pressed[k] = 1'b1;
    wait_row(r);
  endtask

  task automatic test_reset();
    int base, n0;
    logic [3:0] exp_f;
    rst = 1'b1;
    release_all();
    ticks(3);
    total++; if (fila_o !== 4'b0001) begin bad++; $display("FAIL reset_fila: got %b want 0001", fila_o); end
    total++; if (tecla_codigo !== 4'd0) begin bad++; $display("FAIL reset_codigo: got %0d want 0", tecla_codigo); end
    total++; if (tecla_valida !== 1'b0) begin bad++; $display("FAIL reset_valida: got %b want 0", tecla_valida); end
    total++; if (tecla_presionada !== 1'b0) begin bad++; $display("FAIL reset_presionada: got %b want 0", tecla_presionada); end
    total++; if (error_multi !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error_multi); end
    rst = 1'b0;
    base = cyc;
    n0 = pulse_codes.size();
    for (int k = 1; k <= 24; k++) begin
      tick();
      exp_f = row_oh(((cyc - base) / SCAN) % FILAS);
      total++;
      if (fila_o !== exp_f) begin bad++; $display("FAIL scan_seq: cycle %0d got %b want %b", k, fila_o, exp_f); end
    end
    total++; if (pulse_codes.size() != n0) begin bad++; $display("FAIL scan_idle_pulse: got %0d pulses want 0", pulse_codes.size() - n0); end
  endtask

  task automatic test_single_key();
    int n0, rs, rel;
    arm_key(9);
    rs = row_start;
    n0 = pulse_codes.size();
    ticks(SCAN + DEB);
    total++; if (pulse_codes.size() != n0 + 1) begin bad++; $display("FAIL key9_count: got %0d want 1", pulse_codes.size() - n0); end
    if (pulse_codes.size() > n0) begin
      total++; if (pulse_cycles[n0] != rs + SCAN + DEB) begin bad++; $display("FAIL key9_latency: got %0d want %0d", pulse_cycles[n0] - rs, SCAN + DEB); end
      total++; if (pulse_codes[n0] != 9) begin bad++; $display("FAIL key9_code: got %0d want 9", pulse_codes[n0]); end
    end
    total++; if (tecla_presionada !== 1'b1) begin bad++; $display("FAIL key9_held: got %b want 1", tecla_presionada); end
    ticks(int'($urandom_range(10, 40)));
    total++; if (pulse_codes.size() != n0 + 1) begin bad++; $display("FAIL key9_single: got %0d want 1", pulse_codes.size() - n0); end
    pressed[9] = 1'b0;
    rel = cyc + 1;
    ticks(3 + DEB);
    total++; if (tecla_presionada !== 1'b1) begin bad++; $display("FAIL key9_release_early: at +%0d got %b want 1", cyc - rel, tecla_presionada); end
    tick();
    total++; if (tecla_presionada !== 1'b0) begin bad++; $display("FAIL key9_release: at +%0d got %b want 0", cyc - rel, tecla_presionada); end
    total++; if (fila_o !== 4'b1000) begin bad++; $display("FAIL key9_next_row: got %b want 1000", fila_o); end
    total++; if (tecla_codigo !== 4'd9) begin bad++; $display("FAIL key9_code_hold: got %0d want 9", tecla_codigo); end
  endtask

  task automatic test_glitch_press();
    int n0, rs, o;
    n0 = pulse_codes.size();
    for (int g = 0; g < 3; g++) begin
      arm_key(15);
      rs = row_start;
      o = int'($urandom_range(SCAN, SCAN + DEB - 3));
      ticks(o - 1);
      pressed[15] = 1'b0;
      ticks(4);
      total++; if (fila_o !== 4'b0001) begin bad++; $display("FAIL glitch_abort: offset %0d got %b want 0001", o, fila_o); end
    end
    total++; if (pulse_codes.size() != n0) begin bad++; $display("FAIL glitch_pulse: got %0d pulses want 0", pulse_codes.size() - n0); end
    arm_key(15);
    rs = row_start;
    ticks(SCAN + DEB);
    total++; if (pulse_codes.size() != n0 + 1) begin bad++; $display("FAIL key15_count: got %0d want 1", pulse_codes.size() - n0); end
    if (pulse_codes.size() > n0) begin
      total++; if (pulse_codes[n0] != 15) begin bad++; $display("FAIL key15_code: got %0d want 15", pulse_codes[n0]); end
      total++; if (pulse_cycles[n0] != rs + SCAN + DEB) begin bad++; $display("FAIL key15_latency: got %0d want %0d", pulse_cycles[n0] - rs, SCAN + DEB); end
    end
    pressed[15] = 1'b0;
    ticks(4 + DEB);
    total++; if (tecla_presionada !== 1'b0) begin bad++; $display("FAIL key15_release: got %b want 0", tecla_presionada); end
  endtask

  task automatic test_multi_key();
    int n0, e0, rs;
    wait_row(0);
    pressed[4] = 1'b1;
    pressed[6] = 1'b1;
    wait_row(1);
    rs = row_start;
    n0 = pulse_codes.size();
    e0 = err_cycles.size();
    ticks(SCAN);
    total++; if (error_multi !== 1'b1) begin bad++; $display("FAIL multi_pulse: got %b want 1", error_multi); end
    total++; if (fila_o !== 4'b0100) begin bad++; $display("FAIL multi_advance: got %b want 0100", fila_o); end
    release_all();
    tick();
    total++; if (error_multi !== 1'b0) begin bad++; $display("FAIL multi_width: got %b want 0", error_multi); end
    ticks(FILAS * SCAN + 2);
    total++; if (err_cycles.size() != e0 + 1) begin bad++; $display("FAIL multi_count: got %0d want 1", err_cycles.size() - e0); end
    total++; if (pulse_codes.size() != n0) begin bad++; $display("FAIL multi_no_valid: got %0d pulses want 0", pulse_codes.size() - n0); end
  endtask

  task automatic test_release_bounce();
    int k, r, n0, rel;
    for (int it = 0; it < 4; it++) begin
      k = int'($urandom_range(0, NK - 1));
      r = k / COLUMNAS;
      arm_key(k);
      n0 = pulse_codes.size();
      ticks(SCAN + DEB);
      total++; if (pulse_codes.size() != n0 + 1 || pulse_codes[pulse_codes.size() - 1] != k) begin
        bad++; $display("FAIL bounce_accept: key %0d got %0d pulses want 1", k, pulse_codes.size() - n0);
      end
      ticks(int'($urandom_range(4, 12)));
      pressed[k] = 1'b0;
      ticks(int'($urandom_range(1, 5)));
      pressed[k] = 1'b1;
      ticks(20);
      total++; if (tecla_presionada !== 1'b1 || fila_o !== row_oh(r)) begin
        bad++; $display("FAIL bounce_hold: key %0d presionada=%b fila=%b want 1 %b", k, tecla_presionada, fila_o, row_oh(r));
      end
      total++; if (pulse_codes.size() != n0 + 1) begin bad++; $display("FAIL bounce_repulse: key %0d got %0d pulses want 1", k, pulse_codes.size() - n0); end
      pressed[k] = 1'b0;
      rel = cyc + 1;
      ticks(3 + DEB);
      total++; if (tecla_presionada !== 1'b1) begin bad++; $display("FAIL bounce_rel_early: key %0d got %b want 1", k, tecla_presionada); end
      tick();
      total++; if (tecla_presionada !== 1'b0 || fila_o !== row_oh((r + 1) % FILAS)) begin
        bad++; $display("FAIL bounce_rel: key %0d at +%0d presionada=%b fila=%b", k, cyc - rel, tecla_presionada, fila_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    arm_key(int'($urandom_range(0, NK - 1)));
    ticks(int'($urandom_range(SCAN, SCAN + DEB - 2)));
    rst = 1'b1;
    tick();
    total++; if (fila_o !== 4'b0001) begin bad++; $display("FAIL rstmid_fila: got %b want 0001", fila_o); end
    total++; if (tecla_codigo !== 4'd0 || tecla_valida !== 1'b0 || tecla_presionada !== 1'b0 || error_multi !== 1'b0) begin
      bad++; $display("FAIL rstmid_out: codigo=%0d valida=%b pres=%b err=%b want all 0", tecla_codigo, tecla_valida, tecla_presionada, error_multi);
    end
    release_all();
    rst = 1'b0;
    arm_key(5);
    n0 = pulse_codes.size();
    ticks(SCAN + DEB - 1);
    rst = 1'b1;
    tick();
    total++; if (tecla_valida !== 1'b0 || tecla_codigo !== 4'd0) begin
      bad++; $display("FAIL rst_inflight: valida=%b codigo=%0d want 0 0", tecla_valida, tecla_codigo);
    end
    release_all();
    rst = 1'b0;
    ticks(2 * FILAS * SCAN);
    total++; if (pulse_codes.size() != n0) begin bad++; $display("FAIL rst_inflight_late: got %0d pulses want 0", pulse_codes.size() - n0); end
  endtask

  task automatic test_autorepeat();
    int n0, p;
    arm_key(5);
    p = row_start + SCAN + DEB;
    n0 = pulse_codes.size();
    ticks(SCAN + DEB + 100);
    pressed[5] = 1'b0;
    ticks(5 + DEB);
`ifdef AUTOREPEAT_EN
    total++; if (pulse_codes.size() != n0 + 4) begin bad++; $display("FAIL repeat_count: got %0d pulses want 4", pulse_codes.size() - n0); end
    for (int j = 0; j < 4; j++) begin
      if (pulse_codes.size() > n0 + j) begin
        total++; if (pulse_cycles[n0 + j] != p + j * REP || pulse_codes[n0 + j] != 5) begin
          bad++; $display("FAIL repeat_%0d: at +%0d code %0d want +%0d code 5", j, pulse_cycles[n0 + j] - p, pulse_codes[n0 + j], j * REP);
        end
      end
    end
`else
    total++; if (pulse_codes.size() != n0 + 1) begin bad++; $display("FAIL hold_single: got %0d pulses want 1", pulse_codes.size() - n0); end
    if (pulse_codes.size() > n0) begin
      total++; if (pulse_cycles[n0] != p || pulse_codes[n0] != 5) begin
        bad++; $display("FAIL hold_pulse: at +%0d code %0d want +0 code 5", pulse_cycles[n0] - p, pulse_codes[n0]);
      end
    end
`endif
    total++; if (tecla_presionada !== 1'b0) begin bad++; $display("FAIL hold_release: got %b want 0", tecla_presionada); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_key();
    test_glitch_press();
    test_multi_key();
    test_release_bounce();
    test_reset_mid();
    test_autorepeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
